// File: rtl/floating_point_operand_loader.sv
// Operand loader: walks the operand ROM byte by byte and packs every
// four bytes (MSB first) into a 32-bit operand issued over valid/ready.
module floating_point_operand_loader #(
  parameter int NUM_BYTES = 20,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rom_dout,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [31:0]       op_data,
  output logic              op_last,
  output logic              busy,
  output logic              done
);

  // One spare address bit so the end marker fits even at NUM_BYTES = 2**ADDR_W
  localparam int AW = ADDR_W + 1;
  localparam logic [AW-1:0] END_A = AW'(NUM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPT,
    SEND
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] addr_inc;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  assign addr_inc = addr_q + AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          addr_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      READ: begin
        state_d = CAPT;
      end
      CAPT: begin
        data_d = {data_q[23:0], rom_dout};
        addr_d = addr_inc;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = SEND;
          valid_d = 1'b1;
          last_d  = (addr_inc == END_A);
        end else begin
          state_d = READ;
        end
      end
      SEND: begin
        if (op_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            addr_d  = '0;
          end else begin
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_addr  = addr_q[ADDR_W-1:0];
  assign op_valid = valid_q;
  assign op_data  = data_q;
  assign op_last  = last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
